// File: rtl/simpson_integrator_p.sv
// Composite Simpson's-rule integrator over [a, b] with unit step, Horner polynomial
// evaluation, an optional trailing trapezoid interval and an exact restoring divide by 6.
module simpson_integrator_p #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEG   = 3,
  parameter int unsigned ACC_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             error,
  output logic             busy
);

  localparam int unsigned NWORDS = DEG + 3;
  localparam int unsigned IDX_W  = $clog2(NWORDS + 1);
  localparam int unsigned STEP_W = $clog2(DEG + 2);
  localparam int unsigned CNT_W  = $clog2(ACC_W + 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_CHECK,
    S_PAIR,
    S_EVAL,
    S_ACC,
    S_DIV,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ACC_W-1:0]    coef_q [0:DEG];
  logic [ACC_W-1:0]    coef_d [0:DEG];
  logic [W-1:0]        a_q, a_d;
  logic [W-1:0]        b_q, b_d;
  logic [ACC_W-1:0]    x_q, x_d;
  logic [ACC_W-1:0]    bu_q, bu_d;
  logic                odd_q, odd_d;
  logic                trap_q, trap_d;
  logic [ACC_W-1:0]    s_q, s_d;
  logic [ACC_W-1:0]    t_q, t_d;
  logic [ACC_W-1:0]    xp_q, xp_d;
  logic [ACC_W-1:0]    hacc_q, hacc_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [1:0]          pt_q, pt_d;
  logic [ACC_W-1:0]    f_q [0:2];
  logic [ACC_W-1:0]    f_d [0:2];
  logic [ACC_W-1:0]    dvd_q, dvd_d;
  logic [2:0]          rem_q, rem_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [ACC_W-1:0]    out_data_q, out_data_d;
  logic                error_q, error_d;
  logic                busy_q, busy_d;

  logic [ACC_W-1:0]    coef_sel;
  logic [ACC_W-1:0]    prod;
  logic [ACC_W-1:0]    hval;
  logic [3:0]          rem_sh;
  logic                qbit;
  logic                last_pt;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    coef_d      = coef_q;
    a_d         = a_q;
    b_d         = b_q;
    x_d         = x_q;
    bu_d        = bu_q;
    odd_d       = odd_q;
    trap_d      = trap_q;
    s_d         = s_q;
    t_d         = t_q;
    xp_d        = xp_q;
    hacc_d      = hacc_q;
    step_d      = step_q;
    pt_d        = pt_q;
    f_d         = f_q;
    dvd_d       = dvd_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    error_d     = error_q;
    busy_d      = busy_q;

    // Horner step: step 0 seeds with a_DEG, later steps fold in a_(DEG-step).
    coef_sel = '0;
    for (int unsigned k = 0; k <= DEG; k++) begin
      if (k == DEG - 32'(step_q)) coef_sel = coef_q[k];
    end
    prod    = hacc_q * xp_q;
    hval    = (step_q == '0) ? coef_sel : prod + coef_sel;
    last_pt = trap_q ? (pt_q == 2'd1) : (pt_q == 2'd2);

    rem_sh = {rem_q, dvd_q[ACC_W-1]};
    qbit   = (rem_sh >= 4'd6);

    case (state_q)
      S_LOAD: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          for (int unsigned k = 0; k <= DEG; k++) begin
            if (k == 32'(idx_q)) coef_d[k] = ACC_W'(in_data);
          end
          if (32'(idx_q) == DEG + 1) a_d = in_data;
          if (32'(idx_q) == DEG + 2) begin
            b_d        = in_data;
            idx_d      = '0;
            in_ready_d = 1'b0;
            busy_d     = 1'b1;
            state_d    = S_CHECK;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      S_CHECK: begin
        if (a_q >= b_q) begin
          out_valid_d = 1'b1;
          out_data_d  = '0;
          error_d     = 1'b1;
          state_d     = S_ERR;
        end else begin
          odd_d   = a_q[0] ^ b_q[0];
          x_d     = ACC_W'(a_q);
          bu_d    = ACC_W'(b_q) - ACC_W'(a_q[0] ^ b_q[0]);
          s_d     = '0;
          t_d     = '0;
          state_d = S_PAIR;
        end
      end

      S_PAIR: begin
        if (x_q < bu_q) begin
          xp_d    = x_q;
          pt_d    = 2'd0;
          step_d  = '0;
          trap_d  = 1'b0;
          state_d = S_EVAL;
        end else if (odd_q) begin
          xp_d    = bu_q;
          pt_d    = 2'd0;
          step_d  = '0;
          trap_d  = 1'b1;
          state_d = S_EVAL;
        end else begin
          dvd_d   = (s_q << 1) + (t_q << 1) + t_q;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_DIV;
        end
      end

      S_EVAL: begin
        hacc_d = hval;
        if (32'(step_q) == DEG) begin
          case (pt_q)
            2'd0:    f_d[0] = hval;
            2'd1:    f_d[1] = hval;
            default: f_d[2] = hval;
          endcase
          if (last_pt) begin
            state_d = S_ACC;
          end else begin
            pt_d   = pt_q + 1'b1;
            xp_d   = xp_q + 1'b1;
            step_d = '0;
          end
        end else begin
          step_d = step_q + 1'b1;
        end
      end

      S_ACC: begin
        if (trap_q) begin
          // Trapezoid closes the interval; N = 2S + 3T feeds the divider directly.
          t_d     = f_q[0] + f_q[1];
          dvd_d   = (s_q << 1) + (t_d << 1) + t_d;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_DIV;
        end else begin
          s_d     = s_q + f_q[0] + (f_q[1] << 2) + f_q[2];
          x_d     = x_q + ACC_W'(2);
          state_d = S_PAIR;
        end
      end

      S_DIV: begin
        rem_d = qbit ? 3'(rem_sh - 4'd6) : rem_sh[2:0];
        dvd_d = {dvd_q[ACC_W-2:0], qbit};
        if (32'(cnt_q) == ACC_W - 1) begin
          out_data_d  = {dvd_q[ACC_W-2:0], qbit};
          out_valid_d = 1'b1;
          error_d     = 1'b0;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE, S_ERR: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          error_d     = 1'b0;
          busy_d      = 1'b0;
          idx_d       = '0;
          state_d     = S_LOAD;
        end
      end

      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_LOAD;
      idx_q       <= '0;
      coef_q      <= '{default: '0};
      a_q         <= '0;
      b_q         <= '0;
      x_q         <= '0;
      bu_q        <= '0;
      odd_q       <= 1'b0;
      trap_q      <= 1'b0;
      s_q         <= '0;
      t_q         <= '0;
      xp_q        <= '0;
      hacc_q      <= '0;
      step_q      <= '0;
      pt_q        <= '0;
      f_q         <= '{default: '0};
      dvd_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      coef_q      <= coef_d;
      a_q         <= a_d;
      b_q         <= b_d;
      x_q         <= x_d;
      bu_q        <= bu_d;
      odd_q       <= odd_d;
      trap_q      <= trap_d;
      s_q         <= s_d;
      t_q         <= t_d;
      xp_q        <= xp_d;
      hacc_q      <= hacc_d;
      step_q      <= step_d;
      pt_q        <= pt_d;
      f_q         <= f_d;
      dvd_q       <= dvd_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign error     = error_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_simpson_integrator_p.sv
// Directed bench for simpson_integrator_p: hand-computed integrals, errors,
// backpressure, latency and mid-run reset.
module tb_simpson_integrator_p;
  localparam int unsigned W     = 16;
  localparam int unsigned DEG   = 3;
  localparam int unsigned ACC_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             error;
  logic             busy;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;

  always #5 clk = ~clk;

  simpson_integrator_p #(.W(W), .DEG(DEG), .ACC_W(ACC_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .error    (error),
    .busy     (busy)
  );

  // Called at a negedge; returns at the negedge after the word transferred.
  task automatic send_word(input logic [W-1:0] w, output bit ok);
    int unsigned n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    if (ok) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load(input logic [W-1:0] c0, c1, c2, c3, a, b, output bit ok);
    bit o;
    ok = 1'b1;
    send_word(c0, o); ok &= o;
    send_word(c1, o); ok &= o;
    send_word(c2, o); ok &= o;
    send_word(c3, o); ok &= o;
    send_word(a, o);  ok &= o;
    send_word(b, o);  ok &= o;
  endtask

  task automatic wait_valid(input int unsigned limit, output int unsigned cycles, output bit ok);
    cycles = 0;
    while (!out_valid && cycles < limit) begin
      @(negedge clk);
      cycles++;
    end
    ok = out_valid;
  endtask

  task automatic take_output();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({in_ready, out_valid, error, busy} !== 4'b0000)
      $display("FAIL reset_flags got=%b want=0000", {in_ready, out_valid, error, busy});
    else pass_cnt++;
    total_cnt++;
    if (out_data !== '0) $display("FAIL reset_data got=%0d want=0", out_data);
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready_rise got=%b want=1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    bit ok; int unsigned cyc;
    // f = 1 + x^2 on [0,2]: S = 1 + 4*2 + 5 = 14, N = 28, 28/6 = 4
    load(1, 0, 1, 0, 0, 2, ok);
    total_cnt++;
    if (!ok || busy !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL basic_accept got ok=%b busy=%b in_ready=%b want 1 1 0", ok, busy, in_ready);
    else pass_cnt++;
    wait_valid(500, cyc, ok);
    total_cnt++;
    if (!ok || out_data !== 32'd4 || error !== 1'b0)
      $display("FAIL basic_result got=%0d err=%b want=4 err=0", out_data, error);
    else pass_cnt++;
    take_output();
    total_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL basic_release got valid=%b busy=%b want 0 0", out_valid, busy);
    else pass_cnt++;
  endtask

  task automatic test_odd();
    bit ok; int unsigned cyc;
    // f = 1 + x^2 on [0,3]: S = 14, T = 5 + 10 = 15, N = 73, 73/6 = 12
    load(1, 0, 1, 0, 0, 3, ok);
    wait_valid(500, cyc, ok);
    total_cnt++;
    if (!ok || out_data !== 32'd12 || error !== 1'b0)
      $display("FAIL odd_0_3 got=%0d err=%b want=12 err=0", out_data, error);
    else pass_cnt++;
    take_output();
    // f = 1 + x^2 on [0,1]: no pairs, T = 1 + 2 = 3, N = 9, 9/6 = 1
    load(1, 0, 1, 0, 0, 1, ok);
    wait_valid(500, cyc, ok);
    total_cnt++;
    if (!ok || out_data !== 32'd1 || error !== 1'b0)
      $display("FAIL odd_0_1 got=%0d err=%b want=1 err=0", out_data, error);
    else pass_cnt++;
    take_output();
  endtask

  task automatic test_cubic_latency();
    bit ok; int unsigned cyc;
    // f = x^3 on [0,4]: S = 12 + 180 = 192, N = 384, 384/6 = 64.
    // Edges after b: CHECK 1 + 3 PAIR decisions + 2*(3*4 eval + 1 acc) + 32 divide = 62
    load(0, 0, 0, 1, 0, 4, ok);
    wait_valid(500, cyc, ok);
    total_cnt++;
    if (!ok || out_data !== 32'd64 || error !== 1'b0)
      $display("FAIL cubic_result got=%0d err=%b want=64 err=0", out_data, error);
    else pass_cnt++;
    total_cnt++;
    if (cyc !== 62) $display("FAIL cubic_latency got=%0d want=62", cyc);
    else pass_cnt++;
    take_output();
  endtask

  task automatic test_error();
    bit ok; int unsigned cyc;
    load(0, 0, 0, 1, 5, 5, ok);
    wait_valid(50, cyc, ok);
    total_cnt++;
    if (!ok || error !== 1'b1 || out_data !== '0)
      $display("FAIL err_equal got data=%0d err=%b want 0 1", out_data, error);
    else pass_cnt++;
    take_output();
    total_cnt++;
    if (out_valid !== 1'b0 || error !== 1'b0)
      $display("FAIL err_release got valid=%b err=%b want 0 0", out_valid, error);
    else pass_cnt++;
    load(1, 2, 3, 4, 7, 3, ok);
    wait_valid(50, cyc, ok);
    total_cnt++;
    if (!ok || error !== 1'b1 || out_data !== '0)
      $display("FAIL err_reversed got data=%0d err=%b want 0 1", out_data, error);
    else pass_cnt++;
    take_output();
  endtask

  task automatic test_backpressure();
    bit ok; int unsigned cyc; int unsigned bad = 0;
    load(1, 0, 1, 0, 0, 3, ok);
    wait_valid(500, cyc, ok);
    total_cnt++;
    if (!ok) $display("FAIL bp_timeout got valid=%b want=1", out_valid);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = W'(16'h0BAD + i);
      @(negedge clk);
      total_cnt++;
      if (out_valid !== 1'b1 || out_data !== 32'd12 || in_ready !== 1'b0 || busy !== 1'b1) begin
        $display("FAIL bp_hold cycle=%0d got valid=%b data=%0d in_ready=%b busy=%b want 1 12 0 1",
                 i, out_valid, out_data, in_ready, busy);
        bad++;
      end else pass_cnt++;
    end
    in_valid = 1'b0;
    take_output();
    // Junk words during backpressure must not have shifted the load index.
    load(1, 0, 1, 0, 0, 2, ok);
    wait_valid(500, cyc, ok);
    total_cnt++;
    if (!ok || out_data !== 32'd4)
      $display("FAIL bp_next_load got=%0d want=4", out_data);
    else pass_cnt++;
    take_output();
  endtask

  task automatic test_reset_mid();
    bit ok; int unsigned cyc;
    load(0, 0, 0, 1, 0, 100, ok);
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({out_valid, busy, in_ready} !== 3'b000)
      $display("FAIL midreset_flags got=%b want=000", {out_valid, busy, in_ready});
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
    load(0, 0, 0, 1, 0, 4, ok);
    wait_valid(500, cyc, ok);
    total_cnt++;
    if (!ok || out_data !== 32'd64 || error !== 1'b0 || cyc !== 62)
      $display("FAIL midreset_reload got=%0d err=%b cyc=%0d want=64 err=0 cyc=62", out_data, error, cyc);
    else pass_cnt++;
    take_output();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_odd();
    test_cubic_latency();
    test_error();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
